// File: rtl/select_rr_n_pkg.sv
// Shared definitions for the selector family:
// arbitration modes, output-register states, index-width helper.
package select_rr_n_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } sel_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational N-way arbiter, round-robin after ptr or fixed lowest-first.
// Ports: req, ptr, en in; one-hot gnt and encoded gnt_idx out.
module rr_arbiter_n
  import select_rr_n_pkg::*;
#(
  parameter int N     = 4,
  parameter int MODE  = ARB_RR,
  parameter int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  int               idx;
  logic             found;
  logic [SEL_W-1:0] ci;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    ci      = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == ARB_FIXED) begin
        idx = k;
      end else begin
        // ptr < N always, so one wrap step keeps idx in 0..N-1
        idx = int'(ptr) + 1 + k;
        if (idx >= N) idx = idx - N;
      end
      ci = SEL_W'(idx);
      if (!found && req[ci]) begin
        found   = 1'b1;
        gnt_idx = ci;
      end
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/select_rr_n.sv
// N-channel registered selector with valid/ready and fair arbitration.
// Ports: in_data/in_valid/in_ready per channel; out_data/out_src/out_valid/out_ready.
module select_rr_n
  import select_rr_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = clog2(N),
  parameter int MODE  = ARB_RR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  sel_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;

  logic             load_en;
  logic             xfer;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] sel_data;

  assign out_valid = (state_q == S_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign load_en   = !out_valid || out_ready;

  // rst gates the grant so in_ready stays low throughout reset
  rr_arbiter_n #(
    .N     (N),
    .MODE  (MODE),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .en      (load_en && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;
  assign xfer     = |gnt;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (xfer) begin
      state_d = S_FULL;
      data_d  = sel_data;
      src_d   = gnt_idx;
      if (MODE == ARB_RR) ptr_d = gnt_idx;
    end else if (out_valid && out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= SEL_W'(N - 1);
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_select_rr_n.sv
// Scoreboard bench for select_rr_n: RR N=4, RR N=3 and fixed-priority N=4.
// Stimulus pushes hand-computed items; negedge monitors pop on consume.
module tb_select_rr_n;

  logic clk;
  logic rst;

  logic [3:0]   v4, ir4, v4_unused;
  logic [31:0]  d4 [4];
  logic [127:0] dat4;
  logic         or4, ov4;
  logic [31:0]  od4;
  logic [1:0]   os4;

  logic [2:0]   v3, ir3;
  logic [95:0]  dat3;
  logic         or3, ov3;
  logic [31:0]  od3;
  logic [1:0]   os3;

  logic [3:0]   vf, irf;
  logic [127:0] datf;
  logic         orf, ovf;
  logic [31:0]  odf;
  logic [1:0]   osf;

  int errs = 0;
  int checks = 0;

  logic [33:0] q4 [$];
  logic [33:0] q3 [$];
  logic [33:0] qf [$];
  logic [33:0] e4, e3, ef;

  assign v4_unused = '0;
  assign dat4 = {d4[3], d4[2], d4[1], d4[0]};
  assign dat3 = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
  assign datf = {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000};

  select_rr_n #(.WIDTH(32), .N(4), .MODE(0)) u_rr4 (
    .clk(clk), .rst(rst), .in_data(dat4), .in_valid(v4),
    .in_ready(ir4), .out_data(od4), .out_src(os4),
    .out_valid(ov4), .out_ready(or4)
  );

  select_rr_n #(.WIDTH(32), .N(3), .MODE(0)) u_rr3 (
    .clk(clk), .rst(rst), .in_data(dat3), .in_valid(v3),
    .in_ready(ir3), .out_data(od3), .out_src(os3),
    .out_valid(ov3), .out_ready(or3)
  );

  select_rr_n #(.WIDTH(32), .N(4), .MODE(1)) u_fx (
    .clk(clk), .rst(rst), .in_data(datf), .in_valid(vf),
    .in_ready(irf), .out_data(odf), .out_src(osf),
    .out_valid(ovf), .out_ready(orf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && ov4 && or4) begin
      checks++;
      if (q4.size() == 0) begin
        errs++;
        $display("FAIL sb4_extra: got src=%0d data=%h expected none",
                 os4, od4);
      end else begin
        e4 = q4.pop_front();
        if ({os4, od4} !== e4) begin
          errs++;
          $display("FAIL sb4: got src=%0d data=%h expected src=%0d data=%h",
                   os4, od4, e4[33:32], e4[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov3 && or3) begin
      checks++;
      if (q3.size() == 0) begin
        errs++;
        $display("FAIL sb3_extra: got src=%0d data=%h expected none",
                 os3, od3);
      end else begin
        e3 = q3.pop_front();
        if ({os3, od3} !== e3) begin
          errs++;
          $display("FAIL sb3: got src=%0d data=%h expected src=%0d data=%h",
                   os3, od3, e3[33:32], e3[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ovf && orf) begin
      checks++;
      if (qf.size() == 0) begin
        errs++;
        $display("FAIL sbf_extra: got src=%0d data=%h expected none",
                 osf, odf);
      end else begin
        ef = qf.pop_front();
        if ({osf, odf} !== ef) begin
          errs++;
          $display("FAIL sbf: got src=%0d data=%h expected src=%0d data=%h",
                   osf, odf, ef[33:32], ef[31:0]);
        end
      end
    end
  end

  initial begin
    int g;
    rst = 1'b1;
    v4 = '0; v3 = '0; vf = '0;
    or4 = 1'b0; or3 = 1'b0; orf = 1'b0;
    for (int i = 0; i < 4; i++) d4[i] = 32'hC0DE_0000 + i;

    // reset values, in_ready held low during reset
    repeat (2) @(posedge clk);
    #1;
    v4 = 4'hF;
    #1;
    chk("rst_valid", 64'(ov4), 64'(0));
    chk("rst_data", 64'(od4), 64'(0));
    chk("rst_src", 64'(os4), 64'(0));
    chk("rst_ready", 64'(ir4), 64'(0));
    rst = 1'b0;
    or4 = 1'b1;

    // all valid from reset: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      @(negedge clk);
      chk("rr4_gnt", 64'(ir4), 64'(1 << g));
      if (k > 0) chk("rr4_valid", 64'(ov4), 64'(1));
      q4.push_back({2'(g), d4[g]});
    end
    step();
    v4 = '0;
    @(negedge clk);
    step();

    // N=3 with channels 0 and 2: 0,2,0,2
    v3 = 3'b101;
    or3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 0 : 2;
      @(negedge clk);
      chk("rr3_gnt", 64'(ir3), 64'(1 << g));
      q3.push_back({2'(g), 32'h3000_0000 + 32'(g)});
    end
    step();
    v3 = '0;
    @(negedge clk);
    step();

    // fixed priority: channel 1 wins every cycle
    vf = 4'b1110;
    orf = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fix_gnt", 64'(irf), 64'(4'b0010));
      qf.push_back({2'd1, 32'hF000_0001});
    end
    step();
    vf = '0;
    @(negedge clk);
    step();

    // backpressure: hold DEADBEEF from channel 1
    d4[1] = 32'hDEADBEEF;
    v4 = 4'b0010;
    @(negedge clk);
    chk("bp_gnt", 64'(ir4), 64'(4'b0010));
    q4.push_back({2'd1, 32'hDEADBEEF});
    step();
    or4 = 1'b0;
    v4 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 64'(ir4), 64'(0));
      chk("bp_data", 64'(od4), 64'(32'hDEADBEEF));
      chk("bp_src", 64'(os4), 64'(1));
      chk("bp_valid", 64'(ov4), 64'(1));
      step();
    end
    or4 = 1'b1;
    @(negedge clk);
    chk("bp_next", 64'(ir4), 64'(4'b0100));
    q4.push_back({2'd2, d4[2]});
    step();
    v4 = '0;
    @(negedge clk);
    step();

    // single transfer then drain to empty
    v4 = 4'b0001;
    @(negedge clk);
    chk("one_gnt", 64'(ir4), 64'(4'b0001));
    q4.push_back({2'd0, d4[0]});
    step();
    v4 = '0;
    @(negedge clk);
    step();
    chk("empty_valid", 64'(ov4), 64'(0));
    chk("empty_data", 64'(od4), 64'(d4[0]));
    chk("empty_src", 64'(os4), 64'(0));
    v4 = 4'b1000;
    @(negedge clk);
    chk("ch3_gnt", 64'(ir4), 64'(4'b1000));
    q4.push_back({2'd3, d4[3]});
    step();
    v4 = '0;
    @(negedge clk);
    step();

    // async reset while FULL with channel 2 held
    or4 = 1'b0;
    v4 = 4'b0100;
    @(negedge clk);
    chk("pre_rst_gnt", 64'(ir4), 64'(4'b0100));
    step();
    v4 = 4'hF;
    #1;
    chk("pre_rst_valid", 64'(ov4), 64'(1));
    chk("pre_rst_src", 64'(os4), 64'(2));
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(ov4), 64'(0));
    chk("arst_data", 64'(od4), 64'(0));
    chk("arst_ready", 64'(ir4), 64'(0));
    rst = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 64'(ir4), 64'(4'b0001));
    q4.push_back({2'd0, d4[0]});
    step();
    v4 = '0;
    @(negedge clk);
    step();

    chk("q4_drained", 64'(q4.size()), 64'(0));
    chk("q3_drained", 64'(q3.size()), 64'(0));
    chk("qf_drained", 64'(qf.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/select_rr_n.md
# select_rr_n

Parametrised N-channel, WIDTH-bit registered selector with a valid/ready handshake. It picks one requesting input channel per cycle, using round-robin or fixed-priority arbitration, and holds the winner in a single output register. The output is tagged with the source index. It sits wherever the CPU datapath shares one consumer among several producers, for example memory-port sharing between fetch and load/store, or bus-return steering. It replaces the fixed-width, fixed-count combinational selectors where a handshake and fairness are needed.

## Interface
- WIDTH, 32, data width per channel (≥1)
- N, 4, number of input channels (2..16; need not be a power of two)
- SEL_W, $clog2(N), width of the source index
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel request
- in_ready  out  N  per-channel accept; at most one bit high per cycle
- out_data  out  WIDTH  registered selected data
- out_src  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  output register holds an item
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- Two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- load_en = !out_valid || out_ready.
- Grant is computed combinationally from in_valid and the priority pointer ptr.
  - MODE 0: the first valid channel searching ptr+1, ptr+2, … with wrap from N-1 to 0. The search stops at index N-1 for non-power-of-two N, so indices ≥N are never granted.
  - MODE 1: the lowest-index valid channel; ptr is ignored.
- in_ready[g] = load_en && in_valid[g] for the granted g. All other in_ready bits are 0. No in_ready bit is high when no channel is valid.
- Transfer on channel g: in_valid[g] && in_ready[g]. On the next edge:
  - out_data ← in_data[g]
  - out_src ← g
  - out_valid ← 1
  - ptr ← g (MODE 0 only)
- Consume: out_valid && out_ready. If no transfer happens in the same cycle, out_valid ← 0. out_data and out_src hold their last values.
- Consume and transfer in the same cycle: the register is reloaded and out_valid stays 1. This gives 1 item/cycle sustained throughput.
- FULL && !out_ready: out_data, out_src and out_valid are held stable and all in_ready bits are 0 (backpressure).
- The pointer only advances on a transfer. An idle cycle or a stalled cycle leaves ptr unchanged.
- in_valid may drop without a transfer. The arbiter carries no per-channel state.

## Timing
- Reset values:
  - out_valid = 0
  - out_data = 0
  - out_src = 0
  - ptr = N-1, so channel 0 has first priority after reset
  - in_ready = 0 while rst is high
- Latency: input transfer to out_valid is 1 cycle.
- in_ready depends combinationally on in_valid, out_valid and out_ready. There is no combinational path from in_data to any output.
- out_valid, out_data and out_src are purely registered.
- Reset asserted mid-operation clears the output register immediately, without waiting for a clock edge. A held item is dropped. Upstream must treat it as lost.
- Fairness (MODE 0): with all N channels continuously valid and out_ready = 1, each channel is granted exactly once in every N consecutive transfers.

## Structure
- The shared package holds:
  - arbitration-mode constants ARB_RR = 0 and ARB_FIXED = 1
  - a clog2 helper function used for SEL_W across the selector family
- One sub-module: rr_arbiter_n, with parameters N and MODE.
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot gnt[N] and the encoded index gnt_idx.
  - It is purely combinational.
- select_rr_n owns ptr, the output register, the full flag and the data steering.

## Test plan
- Reset release, N=4, all in_valid = 1, out_ready = 1 → grants 0,1,2,3,0 on consecutive cycles. out_src follows one cycle later. out_valid = 1 from the second cycle onward.
- N=3, MODE 0, in_valid = 3'b101 continuously, ptr starting at 2 → grants alternate 0,2,0,2. Index 3 never appears.
- Channel 1 transfers data 0xDEADBEEF, then out_ready = 0 for 5 cycles with all channels valid → out_data stays 0xDEADBEEF, out_src stays 1, in_ready stays 0. Release → the next grant is channel 2.
- MODE 1, in_valid = 4'b1110 held for 4 cycles, out_ready = 1 → channel 1 is granted every cycle and channels 2 and 3 starve.
- Single transfer, then out_ready = 1 with all in_valid = 0 → out_valid falls on the next cycle and out_data is unchanged. The next request from channel 3 is accepted immediately.
- rst pulsed asynchronously between edges while FULL → out_valid drops at once. After release, the first grant is channel 0 even though the last grant before reset was channel 2.
